// File: rtl/hmac512_pkg.sv
// Shared types and helpers for the SHA-512 datapath: word type, block geometry,
// message-schedule sigma functions and the scheduler state encoding.
package hmac512_pkg;

   localparam int NumRound = 80;
   localparam int BlkWords = 16;

   typedef logic [63:0] sha_word_t;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRecv   = 2'd1,
      StExpand = 2'd2
   } sched_st_e;

   // sigma0 = ROTR1 ^ ROTR8 ^ SHR7
   function automatic sha_word_t sigma0_512(input sha_word_t x);
      return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
   endfunction

   // sigma1 = ROTR19 ^ ROTR61 ^ SHR6
   function automatic sha_word_t sigma1_512(input sha_word_t x);
      return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
   endfunction

endpackage

// File: rtl/sha512_msg_sched.sv
// SHA-512 message scheduler: passes the 16 stream words of a block straight
// through as W[0..15], then expands W[16..79] from a 16-word sliding window.
module sha512_msg_sched
   import hmac512_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        sha_en,
   input  logic        hash_start,
   input  logic        shaf_rvalid,
   input  logic [63:0] shaf_rdata,
   output logic        shaf_rready,
   output logic        w_valid,
   output logic [63:0] w_data,
   output logic [6:0]  w_round,
   input  logic        w_ready,
   output logic        block_done
);

   localparam logic [6:0] LastRecv  = 7'(BlkWords - 1);
   localparam logic [6:0] LastRound = 7'(NumRound - 1);

   sched_st_e st;
   logic [6:0] round;
   sha_word_t  win [BlkWords];
   sha_word_t  exp_word;
   logic       w_hs;
   logic       last_round;

   // win[0] is the oldest word (W[t-16]), win[15] the newest (W[t-1]).
   assign exp_word = sigma1_512(win[14]) + win[9] + sigma0_512(win[1]) + win[0];

   // Outputs are gated by sha_en so no handshake is offered that would be ignored.
   always_comb begin
      w_valid     = 1'b0;
      shaf_rready = 1'b0;
      w_data      = '0;
      unique case (st)
         StRecv: begin
            w_valid     = sha_en & shaf_rvalid;
            shaf_rready = sha_en & w_ready;
            w_data      = shaf_rdata;
         end
         StExpand: begin
            w_valid = sha_en;
            w_data  = exp_word;
         end
         default: ;
      endcase
   end

   assign w_hs       = w_valid & w_ready;
   assign last_round = (st == StExpand) && (round == LastRound);
   assign w_round    = round;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         st         <= StIdle;
         round      <= '0;
         block_done <= 1'b0;
         for (int i = 0; i < BlkWords; i++) win[i] <= '0;
      end else begin
         block_done <= 1'b0;
         if (hash_start) begin
            st    <= sha_en ? StRecv : StIdle;
            round <= '0;
            for (int i = 0; i < BlkWords; i++) win[i] <= '0;
         end else if (!sha_en) begin
            st <= StIdle;
         end else if (w_hs) begin
            for (int i = 0; i < BlkWords - 1; i++) win[i] <= win[i+1];
            win[BlkWords-1] <= w_data;
            if (last_round) begin
               round      <= '0;
               st         <= StRecv;
               block_done <= 1'b1;
            end else begin
               round <= round + 7'd1;
               if (st == StRecv && round == LastRecv) st <= StExpand;
            end
         end
      end
   end

endmodule
